// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared timing defaults and types for the VGA scan generator.
//   coord_t      : 10-bit unsigned raster coordinate
//   DEF_*        : 640x480@60 timing from a 50 MHz clock (2 clocks per pixel)
//   H_TOTAL/V_TOTAL : line and frame lengths of the default timing
//   in_window()  : half-open unsigned range test used by the sync decode
// -----------------------------------------------------------------------------
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int   DEF_CLK_DIV   = 2;
  localparam int   DEF_H_VISIBLE = 640;
  localparam int   DEF_H_FRONT   = 16;
  localparam int   DEF_H_SYNC    = 96;
  localparam int   DEF_H_BACK    = 48;
  localparam int   DEF_V_VISIBLE = 480;
  localparam int   DEF_V_FRONT   = 10;
  localparam int   DEF_V_SYNC    = 2;
  localparam int   DEF_V_BACK    = 33;
  localparam logic DEF_SYNC_POL  = 1'b0;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Largest line/frame length the 10-bit coordinate can represent.
  localparam int MAX_TOTAL = 1024;

  // True when c lies in [lo, hi). Bounds are 11 bits so that an upper bound
  // of exactly 1024 (window running to the end of a maximal line) still works.
  function automatic logic in_window(input coord_t c,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
    return ({1'b0, c} >= lo) && ({1'b0, c} < hi);
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// -----------------------------------------------------------------------------
// vga_sync_counter
// Wrapping raster counter with sync and visible-region decode for one axis.
//   i_clk      : system clock
//   i_rst_n    : synchronous active-low reset (count -> 0)
//   i_step     : advance the count by one this clock
//   o_count    : current count, 0..LIMIT-1
//   o_wrap     : count is at LIMIT-1 (next step wraps to 0)
//   o_in_sync  : count in [SYNC_START, SYNC_END)
//   o_in_vis   : count in [0, VISIBLE)
// -----------------------------------------------------------------------------
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int LIMIT      = H_TOTAL,
  parameter int SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT,
  parameter int SYNC_END   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC,
  parameter int VISIBLE    = DEF_H_VISIBLE
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_step,
  output coord_t o_count,
  output logic   o_wrap,
  output logic   o_in_sync,
  output logic   o_in_vis
);

  localparam coord_t      C_LAST       = coord_t'(LIMIT - 1);
  localparam logic [10:0] C_SYNC_START = 11'(SYNC_START);
  localparam logic [10:0] C_SYNC_END   = 11'(SYNC_END);
  localparam logic [10:0] C_VISIBLE    = 11'(VISIBLE);

  coord_t r_count;

  // Position counter: steps when asked, wraps from LIMIT-1 back to 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= 10'd0;
    end else if (i_step) begin
      if (r_count == C_LAST) begin
        r_count <= 10'd0;
      end else begin
        r_count <= r_count + 10'd1;
      end
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count   = r_count;
  assign o_wrap    = (r_count == C_LAST);
  assign o_in_sync = in_window(r_count, C_SYNC_START, C_SYNC_END);
  assign o_in_vis  = in_window(r_count, 11'd0, C_VISIBLE);

endmodule

// File: rtl/vga_scan_generator.sv
// -----------------------------------------------------------------------------
// vga_scan_generator
// VGA raster timing: pixel clock enable, H/V counters, sync and blank. The
// colour mapper reads DrawX/DrawY and returns RGB combinationally; RGB, syncs
// and blank are registered together on the pixel enable so they reach the DAC
// aligned, exactly one pixel after the coordinate that produced them.
//   Clk, Reset_n         : system clock, synchronous active-low reset
//   Pix_R/G/B            : colour for the current DrawX/DrawY
//   DrawX, DrawY         : current horizontal / vertical count
//   pixel_ce             : one-clock strobe per pixel period
//   frame_start          : one-clock pulse after the scan wraps to (0,0)
//   VGA_CLK              : registered pixel clock; outputs change on its fall
//   VGA_HS, VGA_VS       : registered syncs, asserted level SYNC_POL
//   VGA_BLANK_N          : registered, 1 = visible pixel
//   VGA_SYNC_N           : tied 0 (no sync-on-green)
//   VGA_R/G/B            : registered colour, forced to 0 outside visible area
// -----------------------------------------------------------------------------
module vga_scan_generator
  import vga_pkg::*;
#(
  parameter int   CLK_DIV   = DEF_CLK_DIV,
  parameter int   H_VISIBLE = DEF_H_VISIBLE,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   V_VISIBLE = DEF_V_VISIBLE,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter logic SYNC_POL  = DEF_SYNC_POL
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Pix_R,
  input  logic [7:0] Pix_G,
  input  logic [7:0] Pix_B,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       pixel_ce,
  output logic       frame_start,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int HT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] C_DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] C_DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] C_DIV_ZERO = DIV_W'(0);

  // Elaboration-time parameter sanity.
  if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_bad_clk_div
    $error("vga_scan_generator: CLK_DIV must be even and >= 2");
  end
  if ((HT > MAX_TOTAL) || (VT > MAX_TOTAL)) begin : g_bad_total
    $error("vga_scan_generator: H/V totals must not exceed 1024");
  end

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic             w_pixel_ce;
  logic             w_v_step;
  coord_t           w_hc;
  coord_t           w_vc;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_h_sync;
  logic             w_v_sync;
  logic             w_h_vis;
  logic             w_v_vis;
  logic             w_vis;

  logic             r_vga_clk;
  logic             r_frame_start;
  logic             r_hs;
  logic             r_vs;
  logic             r_blank_n;
  logic [7:0]       r_r;
  logic [7:0]       r_g;
  logic [7:0]       r_b;

  // Next divider phase: count 0..CLK_DIV-1 and wrap.
  always_comb begin
    w_div_next = C_DIV_ZERO;
    if (r_div == C_DIV_LAST) begin
      w_div_next = C_DIV_ZERO;
    end else begin
      w_div_next = r_div + C_DIV_ONE;
    end
  end

  // Gated by Reset_n so no strobe escapes while reset is being applied.
  assign w_pixel_ce = (r_div == C_DIV_LAST) & Reset_n;
  assign w_v_step   = w_pixel_ce & w_h_wrap;

  vga_sync_counter #(
    .LIMIT      (HT),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC),
    .VISIBLE    (H_VISIBLE)
  ) u_h_counter (
    .i_clk     (Clk),
    .i_rst_n   (Reset_n),
    .i_step    (w_pixel_ce),
    .o_count   (w_hc),
    .o_wrap    (w_h_wrap),
    .o_in_sync (w_h_sync),
    .o_in_vis  (w_h_vis)
  );

  vga_sync_counter #(
    .LIMIT      (VT),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC),
    .VISIBLE    (V_VISIBLE)
  ) u_v_counter (
    .i_clk     (Clk),
    .i_rst_n   (Reset_n),
    .i_step    (w_v_step),
    .o_count   (w_vc),
    .o_wrap    (w_v_wrap),
    .o_in_sync (w_v_sync),
    .o_in_vis  (w_v_vis)
  );

  assign w_vis = w_h_vis & w_v_vis;

  // Divider, pixel clock and frame pulse. VGA_CLK is derived from the next
  // divider phase so the register reads 1 exactly while div >= CLK_DIV/2.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_div         <= C_DIV_ZERO;
      r_vga_clk     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_div_next;
      r_vga_clk     <= (w_div_next >= C_DIV_HALF);
      r_frame_start <= w_pixel_ce & w_h_wrap & w_v_wrap;
    end
  end

  // Output stage: colour, blank and syncs for the pixel just finished.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_r       <= 8'd0;
      r_g       <= 8'd0;
      r_b       <= 8'd0;
      r_blank_n <= 1'b0;
      r_hs      <= ~SYNC_POL;
      r_vs      <= ~SYNC_POL;
    end else if (w_pixel_ce) begin
      r_r       <= w_vis ? Pix_R : 8'd0;
      r_g       <= w_vis ? Pix_G : 8'd0;
      r_b       <= w_vis ? Pix_B : 8'd0;
      r_blank_n <= w_vis;
      r_hs      <= w_h_sync ? SYNC_POL : ~SYNC_POL;
      r_vs      <= w_v_sync ? SYNC_POL : ~SYNC_POL;
    end else begin
      r_r       <= r_r;
      r_g       <= r_g;
      r_b       <= r_b;
      r_blank_n <= r_blank_n;
      r_hs      <= r_hs;
      r_vs      <= r_vs;
    end
  end

  assign DrawX       = w_hc;
  assign DrawY       = w_vc;
  assign pixel_ce    = w_pixel_ce;
  assign frame_start = r_frame_start;
  assign VGA_CLK     = r_vga_clk;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_r;
  assign VGA_G       = r_g;
  assign VGA_B       = r_b;

endmodule

// File: tb/tb_vga_scan_generator.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_generator
// Bench for vga_scan_generator. Horizontal timing is the 640x480 default; the
// vertical timing is shortened (6/2/2/3 lines, 13 total) so whole frames fit
// in a short run. The expected outputs are computed in closed form from the
// number of clock edges since reset was last released; the colour mapper is
// modelled as a function of the coordinates, with deliberately wrong colour
// driven on cycles where the pixel must not be sampled.
// -----------------------------------------------------------------------------
module tb_vga_scan_generator;

  localparam int CLK_DIV = 2;
  localparam int HV = 640, HF = 16, HSW = 96, HB = 48;
  localparam int VV = 6,   VF = 2,  VSW = 2,  VB = 3;
  localparam int HT = HV + HF + HSW + HB;   // 800
  localparam int VT = VV + VF + VSW + VB;   // 13

  logic       clk     = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] Pix_R   = 8'd0;
  logic [7:0] Pix_G   = 8'd0;
  logic [7:0] Pix_B   = 8'd0;
  logic [9:0] DrawX, DrawY;
  logic       pixel_ce, frame_start, VGA_CLK, VGA_HS, VGA_VS;
  logic       VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  int errors = 0;
  int checks = 0;
  int k      = 0;     // clock edges since reset was last sampled low
  bit model_valid = 1'b0;

  vga_scan_generator #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB), .SYNC_POL(1'b0)
  ) dut (
    .Clk(clk), .Reset_n(Reset_n),
    .Pix_R(Pix_R), .Pix_G(Pix_G), .Pix_B(Pix_B),
    .DrawX(DrawX), .DrawY(DrawY), .pixel_ce(pixel_ce), .frame_start(frame_start),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 clk = ~clk;

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      if (errors >= 50) finish_run();
    end
  endtask

  // Colour mapper model.
  function automatic logic [23:0] colour(input int h, input int v);
    logic [7:0] r, g, b;
    r = (h == HV - 1 && v == 0) ? 8'hFF : 8'(h + v);
    g = 8'((h * 3) ^ v);
    b = 8'(h + 7 * v + 17);
    return {r, g, b};
  endfunction

  // Colour presented during the cycle after kk edges: correct only on the
  // last clock of the pixel, inverted otherwise.
  function automatic logic [23:0] pix_for(input int kk);
    int n;
    n = kk / CLK_DIV;
    if ((kk % CLK_DIV) == CLK_DIV - 1) return colour(n % HT, (n / HT) % VT);
    return ~colour(n % HT, (n / HT) % VT);
  endfunction

  // Expected output vector after kk edges out of reset.
  function automatic logic [50:0] expect_at(input int kk, input logic rst_now);
    int div, n, h, v, pn, ph, pv;
    logic ce, fs, vclk, hs, vs, bl;
    logic [23:0] rgb;
    div  = kk % CLK_DIV;
    n    = kk / CLK_DIV;
    h    = n % HT;
    v    = (n / HT) % VT;
    ce   = rst_now && (div == CLK_DIV - 1);
    vclk = (div >= CLK_DIV / 2);
    fs   = (div == 0) && (n > 0) && ((n % (HT * VT)) == 0);
    if (n == 0) begin
      hs = 1'b1; vs = 1'b1; bl = 1'b0; rgb = 24'd0;
    end else begin
      pn  = n - 1;
      ph  = pn % HT;
      pv  = (pn / HT) % VT;
      bl  = (ph < HV) && (pv < VV);
      hs  = !((ph >= HV + HF) && (ph < HV + HF + HSW));
      vs  = !((pv >= VV + VF) && (pv < VV + VF + VSW));
      rgb = bl ? colour(ph, pv) : 24'd0;
    end
    return {10'(h), 10'(v), ce, fs, vclk, hs, vs, bl, 1'b0, rgb};
  endfunction

  function automatic logic sel_bit(input int sel);
    case (sel)
      0:       return VGA_HS;
      1:       return VGA_VS;
      default: return frame_start;
    endcase
  endfunction

  // Edge counter for the model.
  always @(posedge clk) begin
    if (!Reset_n) begin
      k <= 0;
      model_valid <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  // Colour mapper: drive the next cycle's colour.
  always @(negedge clk) begin
    {Pix_R, Pix_G, Pix_B} = pix_for(k);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_valid)
      check("cycle", {13'd0, DrawX, DrawY, pixel_ce, frame_start, VGA_CLK, VGA_HS,
                      VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B},
            {13'd0, expect_at(k, Reset_n)});
  end

  task automatic wait_xy(input int x, input int y, input int limit, input string nm);
    int i = 0;
    while (!(DrawX == 10'(x) && DrawY == 10'(y)) && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (i >= limit) begin
      checks++; errors++;
      $display("FAIL %s: timeout after %0d cycles", nm, limit);
    end
  endtask

  task automatic wait_bit(input int sel, input logic lvl, input int limit, input string nm);
    int i = 0;
    while (sel_bit(sel) !== lvl && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (i >= limit) begin
      checks++; errors++;
      $display("FAIL %s: timeout after %0d cycles", nm, limit);
    end
  endtask

  task automatic count_low(input int sel, input int limit, output int n);
    n = 0;
    while (sel_bit(sel) == 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k1;
    // Reset held for 5 clocks.
    Reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_drawx", DrawX, 0);
    check("rst_drawy", DrawY, 0);
    check("rst_hs", VGA_HS, 1);
    check("rst_vs", VGA_VS, 1);
    check("rst_blank", VGA_BLANK_N, 0);
    check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    check("rst_vgaclk", VGA_CLK, 0);
    check("rst_ce", pixel_ce, 0);
    #2 Reset_n = 1'b1;

    // First pixel period.
    @(negedge clk);
    check("ce_first", pixel_ce, 1);
    check("vgaclk_first", VGA_CLK, 1);
    @(negedge clk);
    check("drawx_step", DrawX, 1);
    check("ce_gap", pixel_ce, 0);

    // Last visible pixel colour appears one pixel later; blanking after that.
    wait_xy(640, 0, 2000, "wait_x640");
    check("r_after_639", VGA_R, 8'hFF);
    check("blank_after_639", VGA_BLANK_N, 1);
    wait_xy(641, 0, 10, "wait_x641");
    check("r_after_640", VGA_R, 0);
    check("blank_after_640", VGA_BLANK_N, 0);

    // Horizontal sync placement and width.
    wait_bit(0, 1'b0, 2000, "wait_hs_fall");
    check("hs_fall_x", DrawX, 657);
    count_low(0, 1000, n);
    check("hs_low_clks", n, 192);

    // Line wrap after 1600 clocks.
    wait_xy(0, 1, 2000, "wait_line_wrap");
    check("line_wrap_clks", k, 1600);

    // Vertical sync only for lines 8-9 (shown one pixel late).
    wait_bit(1, 1'b0, 30000, "wait_vs_fall");
    check("vs_fall_y", DrawY, 8);
    check("vs_fall_x", DrawX, 1);
    count_low(1, 10000, n);
    check("vs_low_clks", n, 3200);

    // Frame pulses: one clock wide, 2*800*13 clocks apart.
    wait_bit(2, 1'b1, 30000, "wait_fs1");
    check("fs1_clks", k, 20800);
    k1 = k;
    @(negedge clk);
    check("fs_width", frame_start, 0);
    wait_bit(2, 1'b1, 30000, "wait_fs2");
    check("fs_period", k - k1, 20800);

    // Reset mid-frame.
    wait_xy(300, 3, 30000, "wait_x300");
    #2 Reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_drawx", DrawX, 0);
    check("mid_rst_drawy", DrawY, 0);
    check("mid_rst_hs", VGA_HS, 1);
    check("mid_rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    repeat (2) @(negedge clk);
    #2 Reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("resume_drawx", DrawX, 5);
    check("resume_drawy", DrawY, 0);

    repeat (3000) @(negedge clk);
    finish_run();
  end

endmodule
